instr_dcd_burst: RTL and testbench

- Parametrised successor to the single-access SPI instruction decoder.
- Sits between the SPI slave byte interface and the register file.
- Decodes one command byte per chip-select frame, then services an unbounded burst of data bytes. Each data byte causes a register read or write.
- Auto-increment is optional, with wrap at a programmable last address; frames are explicitly bounded by chip-select start and end strobes.

---
 rtl/instr_dcd_burst.sv | 213 +++++++++++++++++++++
 tb/tb_instr_dcd_burst.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dcd_burst.sv
// ----------------------------------------------------------------------------
// instr_dcd_burst
// Burst-capable SPI instruction decoder. Each chip-select frame carries one
// command byte followed by any number of data bytes. Every data byte turns
// into one register write (write command) or one register read (read
// command, with a read issued immediately after the command byte so the
// first reply is ready in time). Optional address auto-increment wraps from
// ADDR_LAST back to 0.
//
// Ports
//   clk_i          peripheral clock, rising edge
//   rst_i          synchronous active-high reset
//   frame_start_i  one-cycle pulse, chip-select asserted
//   frame_end_i    one-cycle pulse, chip-select deasserted
//   byte_sync_i    one-cycle pulse, data_in_i holds a complete byte
//   data_in_i      received SPI byte
//   data_out_o     byte to shift out on MISO (registered)
//   read_o         one-cycle register read strobe
//   write_o        one-cycle register write strobe
//   addr_o         register address (registered)
//   data_read_i    register read data, valid in the cycle read_o=1
//   data_write_o   register write data (registered)
//   busy_o         high from frame_start until frame_end
//   xfer_cnt_o     data bytes serviced in this frame, saturating
//
// Command byte: [DATA_W-1]=RW (1=write), [DATA_W-2]=INC, [ADDR_W-1:0]=base.
// ----------------------------------------------------------------------------
module instr_dcd_burst #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int ADDR_LAST = 2**ADDR_W-1,
   parameter int CNT_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              frame_start_i,
   input  logic              frame_end_i,
   input  logic              byte_sync_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic              read_o,
   output logic              write_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic [DATA_W-1:0] data_read_i,
   output logic [DATA_W-1:0] data_write_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  xfer_cnt_o
);

   localparam logic [ADDR_W-1:0] ADDR_LAST_C = ADDR_W'(ADDR_LAST);
   localparam logic [CNT_W-1:0]  CNT_MAX_C   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                inc_q, inc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [DATA_W-1:0]   data_write_q, data_write_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Next register address with wrap at the programmable last address.
   function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] n;
      if (a == ADDR_LAST_C) begin
         n = {ADDR_W{1'b0}};
      end else begin
         n = a + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      return n;
   endfunction

   // Saturating increment of the data-byte counter.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] n;
      if (c == CNT_MAX_C) begin
         n = c;
      end else begin
         n = c + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return n;
   endfunction

   // Next-state and next-output computation for the decoder FSM.
   always_comb begin
      state_d      = state_q;
      inc_d        = inc_q;
      addr_d       = addr_q;
      data_out_d   = data_out_q;
      data_write_d = data_write_q;
      read_d       = 1'b0;
      write_d      = 1'b0;
      busy_d       = busy_q;
      cnt_d        = cnt_q;

      if (frame_start_i) begin
         // New frame (or abort of the running one): any byte in flight is dropped.
         state_d    = ST_CMD;
         busy_d     = 1'b1;
         cnt_d      = {CNT_W{1'b0}};
         data_out_d = {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_CMD: begin
               if (byte_sync_i) begin
                  inc_d  = data_in_i[DATA_W-2];
                  addr_d = data_in_i[ADDR_W-1:0];
                  if (data_in_i[DATA_W-1]) begin
                     state_d = ST_WDATA;
                  end else begin
                     // Prefetch the first read so its data is on MISO for byte 1.
                     state_d = ST_RDATA;
                     read_d  = 1'b1;
                  end
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_WDATA: begin
               // Advance only once the write strobe has used the current address.
               if (write_q && inc_q) begin
                  addr_d = addr_next(addr_q);
               end else begin
                  addr_d = addr_q;
               end
               if (byte_sync_i) begin
                  write_d      = 1'b1;
                  data_write_d = data_in_i;
                  cnt_d        = cnt_next(cnt_q);
               end else begin
                  write_d = 1'b0;
               end
            end
            ST_RDATA: begin
               if (read_q) begin
                  data_out_d = data_read_i;
               end else begin
                  data_out_d = data_out_q;
               end
               if (byte_sync_i) begin
                  // Previous reply has been shifted; fetch the next one.
                  cnt_d  = cnt_next(cnt_q);
                  read_d = 1'b1;
                  if (inc_q) begin
                     addr_d = addr_next(addr_q);
                  end else begin
                     addr_d = addr_q;
                  end
               end else begin
                  read_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // A coincident byte is still processed above; only the frame closes here.
         if (frame_end_i) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            data_out_d = {DATA_W{1'b0}};
         end else begin
            busy_d = busy_q;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         inc_q        <= 1'b0;
         addr_q       <= {ADDR_W{1'b0}};
         data_out_q   <= {DATA_W{1'b0}};
         data_write_q <= {DATA_W{1'b0}};
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         inc_q        <= inc_d;
         addr_q       <= addr_d;
         data_out_q   <= data_out_d;
         data_write_q <= data_write_d;
         read_q       <= read_d;
         write_q      <= write_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign data_out_o   = data_out_q;
   assign read_o       = read_q;
   assign write_o      = write_q;
   assign addr_o       = addr_q;
   assign data_write_o = data_write_q;
   assign busy_o       = busy_q;
   assign xfer_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_dcd_burst.sv
// ----------------------------------------------------------------------------
// tb_instr_dcd_burst
// Scoreboard bench for instr_dcd_burst. Stimulus tasks compute the expected
// register accesses for each frame from the command byte and push them into a
// queue; a negedge monitor pops one entry per strobe and compares address,
// direction, write data and the resulting data_out.
// ----------------------------------------------------------------------------
module tb_instr_dcd_burst;

   localparam int LAST = 63;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start, frame_end, byte_sync;
   logic [7:0] data_in, data_out, data_read, data_write;
   logic       rd, wr, busy;
   logic [5:0] addr;
   logic [7:0] xfer_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         w;
      logic [5:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] tb_mem  [64] = '{default: 8'h00};
   logic [7:0] ref_mem [64] = '{default: 8'h00};

   instr_dcd_burst dut (
      .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .frame_end_i(frame_end),
      .byte_sync_i(byte_sync), .data_in_i(data_in), .data_out_o(data_out),
      .read_o(rd), .write_o(wr), .addr_o(addr), .data_read_i(data_read),
      .data_write_o(data_write), .busy_o(busy), .xfer_cnt_o(xfer_cnt)
   );

   always #5 clk = ~clk;

   // Register file behind the decoder.
   assign data_read = tb_mem[addr];
   always @(posedge clk) begin
      if (wr) tb_mem[addr] <= data_write;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // Monitor: one scoreboard entry per strobe, data_out checked a cycle after a read.
   bit         dout_chk = 1'b0;
   logic [7:0] dout_exp;
   always @(negedge clk) begin
      exp_t e;
      if (dout_chk) begin
         check("data_out", {24'h0, data_out}, {24'h0, dout_exp});
         dout_chk = 1'b0;
      end
      if (rd || wr) begin
         if (rd && wr) check("strobe_excl", 32'd1, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'h0, wr, rd}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {31'h0, wr}, {31'h0, e.w});
            check("strobe_addr", {26'h0, addr}, {26'h0, e.a});
            if (e.w) begin
               check("data_write", {24'h0, data_write}, {24'h0, e.d});
            end else begin
               dout_chk = 1'b1;
               dout_exp = e.d;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] nxt(input logic [5:0] a);
      int v;
      v = (int'(a) == LAST) ? 0 : (int'(a) + 1) % 64;
      return v[5:0];
   endfunction

   task automatic push_exp(input bit w, input logic [5:0] a, input logic [7:0] d);
      exp_t e;
      e.w = w; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_in   = b;
      byte_sync = 1'b1;
      tick();
      byte_sync = 1'b0;
      repeat (8) tick();
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("busy_start", {31'h0, busy}, 32'd1);
      check("cnt_start", {24'h0, xfer_cnt}, 32'd0);
      repeat (2) tick();
   endtask

   task automatic end_frame(input int n);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      check("busy_end", {31'h0, busy}, 32'd0);
      check("dout_end", {24'h0, data_out}, 32'd0);
      check("cnt_hold", {24'h0, xfer_cnt}, (n > 255) ? 32'd255 : n);
      repeat (2) tick();
   endtask

   // One full frame: model the expected accesses, drive the bytes.
   task automatic run_frame(input logic [7:0] cmd, input int n, input bit close,
                            input bit use_list, input logic [7:0] l0,
                            input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3);
      logic [5:0] a;
      logic [7:0] d;
      bit         w, inc;
      w   = cmd[7];
      inc = cmd[6];
      a   = cmd[5:0];
      start_frame();
      if (!w) push_exp(1'b0, a, ref_mem[a]);
      send_byte(cmd);
      for (int k = 0; k < n; k++) begin
         if (use_list) d = (k == 0) ? l0 : (k == 1) ? l1 : (k == 2) ? l2 : l3;
         else d = 8'($urandom_range(0, 255));
         if (w) begin
            push_exp(1'b1, a, d);
            ref_mem[a] = d;
            send_byte(d);
            if (inc) a = nxt(a);
         end else begin
            if (inc) a = nxt(a);
            push_exp(1'b0, a, ref_mem[a]);
            send_byte(d);
         end
      end
      check("cnt_frame", {24'h0, xfer_cnt}, (n > 255) ? 32'd255 : n);
      if (close) end_frame(n);
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; byte_sync = 1'b0; data_in = 8'h00;
      repeat (3) tick();
      check("rst_dout", {24'h0, data_out}, 32'd0);
      check("rst_strobes", {30'h0, rd, wr}, 32'd0);
      check("rst_addr", {26'h0, addr}, 32'd0);
      check("rst_dw", {24'h0, data_write}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_cnt", {24'h0, xfer_cnt}, 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Single write, preload, INC burst read, wrap, no-INC read.
      run_frame(8'h85, 1, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h00, 8'h00);
      run_frame(8'hD0, 4, 1'b1, 1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      run_frame(8'h50, 3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(8'hFE, 3, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h00);
      run_frame(8'h87, 1, 1'b1, 1'b1, 8'h6E, 8'h00, 8'h00, 8'h00);
      run_frame(8'h07, 2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Frame ends after the command byte only: no access.
      run_frame(8'h85, 0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Data byte coincident with frame_end: the write still happens.
      start_frame();
      send_byte(8'h8A);
      push_exp(1'b1, 6'h0A, 8'h5A);
      ref_mem[6'h0A] = 8'h5A;
      data_in = 8'h5A; byte_sync = 1'b1; frame_end = 1'b1;
      tick();
      byte_sync = 1'b0; frame_end = 1'b0;
      check("coinc_busy", {31'h0, busy}, 32'd0);
      repeat (3) tick();
      check("coinc_cnt", {24'h0, xfer_cnt}, 32'd1);

      // frame_start mid-burst aborts and restarts (start_frame checks cnt=0).
      run_frame(8'hC0, 2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(8'h40, 2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Counter saturation.
      run_frame(8'hA0, 260, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Randomized frames.
      for (int f = 0; f < 16; f++) begin
         run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5), 1'b1, 1'b0,
                   8'h00, 8'h00, 8'h00, 8'h00);
      end

      // Reset in the middle of a write burst; later stray byte is ignored.
      run_frame(8'hC1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_out", {6'h0, data_out, data_write, addr, rd, wr, busy, xfer_cnt != 8'h0}, 32'd0);
      send_byte(8'h99);
      check("mrst_idle_busy", {31'h0, busy}, 32'd0);
      check("mrst_idle_cnt", {24'h0, xfer_cnt}, 32'd0);

      repeat (4) tick();
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
